// File: rtl/pipe_types_pkg.sv
// Shared pipeline-stage types: payload structs, NOP encodings, occupancy
// state codes and the wrapping pointer increment used by stage buffers.
package pipe_types_pkg;

  // Widest pointer any stage buffer needs (DEPTH <= 8).
  localparam int unsigned PTR_MAX_W = 3;

  // Occupancy states, derived from the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // ID/EX payload; packs to 64 bits to match the default stage width.
  typedef struct packed {
    logic [15:0] rdat1;
    logic [15:0] rdat2;
    logic [15:0] imm;
    logic [11:0] pc;
    logic [3:0]  ctrl;
  } id_ex_t;

  localparam id_ex_t      ID_EX_NOP    = '0;
  localparam logic [63:0] BUBBLE_NOP64 = '0;

  // Advance a buffer pointer, wrapping from depth-1 back to 0.
  function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                   input int unsigned           depth);
    if (int'(ptr) >= int'(depth) - 1) return '0;
    return ptr + PTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_occ_ctr.sv
// Occupancy tracker for a stage buffer: entry count plus read/write pointers.
// Flush and reset both return everything to the empty position.
module pipe_occ_ctr
  import pipe_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Next count/pointers: flush clears, otherwise push/pop advance independently.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = PTR_W'(ptr_inc(PTR_MAX_W'(wr_ptr_q), DEPTH));
      if (pop_i)  rd_ptr_d = PTR_W'(ptr_inc(PTR_MAX_W'(rd_ptr_q), DEPTH));
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign count_o  = count_q;
  assign rd_ptr_o = rd_ptr_q;
  assign wr_ptr_o = wr_ptr_q;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register: valid/ready handshake over a
// DEPTH-entry in-order buffer. in_ready depends only on registered occupancy,
// so downstream stalls never create a combinational upstream path.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W = 64,
  parameter int unsigned       DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+2)-1:0]   squashed
);
  import pipe_types_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SQ_W  = $clog2(DEPTH + 2);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              full, empty, push, pop;
  logic [1:0]        state;
  logic [SQ_W-1:0]   squashed_q, squashed_d;

  pipe_occ_ctr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_occ (
    .clk_i    (CLK),
    .rst_i    (RST),
    .flush_i  (flush),
    .push_i   (push),
    .pop_i    (pop),
    .count_o  (count),
    .rd_ptr_o (rd_ptr),
    .wr_ptr_o (wr_ptr),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Occupancy state derived from the registered count.
  always_comb begin
    state = ST_PART;
    if (empty)     state = ST_EMPTY;
    else if (full) state = ST_FULL;
  end

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = out_valid ? mem_q[rd_ptr] : BUBBLE;

  // Payload storage; entries are masked by occupancy, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr] <= in_data;
  end

  // A flush records buffered beats plus the beat offered alongside it.
  always_comb begin
    squashed_d = squashed_q;
    if (flush) squashed_d = SQ_W'(count) + SQ_W'(in_valid & in_ready);
  end

  // Squash counter holds until the next flush.
  always_ff @(posedge CLK) begin
    if (RST) squashed_q <= '0;
    else     squashed_q <= squashed_d;
  end

  assign squashed = squashed_q;

  a_count_bound: assert property (@(posedge CLK) disable iff (RST)
    count <= CNT_W'(DEPTH));

  a_no_push_full: assert property (@(posedge CLK) disable iff (RST)
    !(push && !in_ready));

  a_hold_stable: assert property (@(posedge CLK) disable iff (RST)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 instance for reset, streaming,
// stall, flush and mid-stall reset, and a DEPTH=3 instance for pointer wrap.
module tb_pipe_stage_buf;

  localparam logic [63:0] BUB3 = 64'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;

  // DEPTH=2 instance
  logic        fl2 = 1'b0, iv2 = 1'b0, ordy2 = 1'b0;
  logic [63:0] id2 = '0;
  logic        irdy2, ov2;
  logic [63:0] od2;
  logic [1:0]  cnt2;
  logic [1:0]  sq2;

  // DEPTH=3 instance
  logic        fl3 = 1'b0, iv3 = 1'b0, ordy3 = 1'b0;
  logic [63:0] id3 = '0;
  logic        irdy3, ov3;
  logic [63:0] od3;
  logic [1:0]  cnt3;
  logic [2:0]  sq3;

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2)) u_dut2 (
    .CLK(clk), .RST(rst), .flush(fl2), .in_valid(iv2), .in_ready(irdy2),
    .in_data(id2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2),
    .count(cnt2), .squashed(sq2)
  );

  pipe_stage_buf #(.DATA_W(64), .DEPTH(3), .BUBBLE(BUB3)) u_dut3 (
    .CLK(clk), .RST(rst), .flush(fl3), .in_valid(iv3), .in_ready(irdy3),
    .in_data(id3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .count(cnt3), .squashed(sq3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // obs/exp layout for DEPTH=2: {out_valid, in_ready, count, squashed, out_data}
  task automatic test_reset();
    logic [69:0] exp2;
    logic [72:0] exp3;
    rst = 1'b1;
    step();
    step();
    exp2 = {1'b0, 1'b1, 2'd0, 2'd0, 64'd0};
    total++;
    if ({ov2, irdy2, cnt2, sq2, od2} !== exp2) begin
      bad++;
      $display("FAIL reset_d2: got %h want %h", {ov2, irdy2, cnt2, sq2, od2}, exp2);
    end
    exp3 = {1'b0, 1'b1, 2'd0, 3'd0, BUB3};
    total++;
    if ({ov3, irdy3, cnt3, sq3, od3} !== exp3) begin
      bad++;
      $display("FAIL reset_d3: got %h want %h", {ov3, irdy3, cnt3, sq3, od3}, exp3);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] din [3];
    logic [69:0] exp2;
    din = '{64'h11, 64'h22, 64'h33};
    ordy2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv2 = (i < 3);
      id2 = (i < 3) ? din[i] : 64'h0;
      step();
      exp2 = (i < 3) ? {1'b1, 1'b1, 2'd1, 2'd0, din[i]} : {1'b0, 1'b1, 2'd0, 2'd0, 64'd0};
      total++;
      if ({ov2, irdy2, cnt2, sq2, od2} !== exp2) begin
        bad++;
        $display("FAIL stream_%0d: got %h want %h", i, {ov2, irdy2, cnt2, sq2, od2}, exp2);
      end
    end
    iv2 = 1'b0;
  endtask

  task automatic test_stall();
    logic        v_iv [7];
    logic [63:0] v_id [7];
    logic        v_or [7];
    logic [69:0] v_ex [7];
    v_iv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v_id = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'hC, 64'h0};
    v_or = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    v_ex = '{{1'b1, 1'b1, 2'd1, 2'd0, 64'hA},
             {1'b1, 1'b0, 2'd2, 2'd0, 64'hA},
             {1'b1, 1'b0, 2'd2, 2'd0, 64'hA},
             {1'b1, 1'b0, 2'd2, 2'd0, 64'hA},
             {1'b1, 1'b1, 2'd1, 2'd0, 64'hB},
             {1'b1, 1'b1, 2'd1, 2'd0, 64'hC},
             {1'b0, 1'b1, 2'd0, 2'd0, 64'h0}};
    for (int i = 0; i < 7; i++) begin
      iv2   = v_iv[i];
      id2   = v_id[i];
      ordy2 = v_or[i];
      step();
      total++;
      if ({ov2, irdy2, cnt2, sq2, od2} !== v_ex[i]) begin
        bad++;
        $display("FAIL stall_%0d: got %h want %h", i, {ov2, irdy2, cnt2, sq2, od2}, v_ex[i]);
      end
    end
    iv2 = 1'b0;
  endtask

  task automatic test_flush();
    logic        v_iv [8];
    logic [63:0] v_id [8];
    logic        v_fl [8];
    logic        v_or [8];
    logic [69:0] v_ex [8];
    v_iv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v_id = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h0, 64'h0, 64'h0};
    v_fl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    v_or = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    v_ex = '{{1'b1, 1'b1, 2'd1, 2'd0, 64'h1},
             {1'b1, 1'b0, 2'd2, 2'd0, 64'h1},
             {1'b0, 1'b1, 2'd0, 2'd2, 64'h0},
             {1'b1, 1'b1, 2'd1, 2'd2, 64'h4},
             {1'b0, 1'b1, 2'd0, 2'd2, 64'h0},
             {1'b0, 1'b1, 2'd0, 2'd2, 64'h0},
             {1'b0, 1'b1, 2'd0, 2'd0, 64'h0},
             {1'b0, 1'b1, 2'd0, 2'd0, 64'h0}};
    for (int i = 0; i < 8; i++) begin
      iv2   = v_iv[i];
      id2   = v_id[i];
      fl2   = v_fl[i];
      ordy2 = v_or[i];
      step();
      total++;
      if ({ov2, irdy2, cnt2, sq2, od2} !== v_ex[i]) begin
        bad++;
        $display("FAIL flush_%0d: got %h want %h", i, {ov2, irdy2, cnt2, sq2, od2}, v_ex[i]);
      end
    end
    fl2 = 1'b0;
    iv2 = 1'b0;
  endtask

  task automatic test_wrap();
    logic [63:0] q [$];
    logic [72:0] exp3;
    logic [63:0] front;
    int unsigned sent = 0;
    int unsigned got  = 0;
    logic        mpush, mpop;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      iv3   = (sent < 10);
      id3   = 64'h100 + 64'(sent);
      ordy3 = 1'($urandom_range(1, 0));
      mpush = iv3 && (q.size() != 3);
      mpop  = ordy3 && (q.size() != 0);
      step();
      if (mpop) begin
        void'(q.pop_front());
        got++;
      end
      if (mpush) begin
        q.push_back(id3);
        sent++;
      end
      front = (q.size() != 0) ? q[0] : BUB3;
      exp3 = {q.size() != 0, q.size() != 3, 2'(q.size()), 3'd0, front};
      total++;
      if ({ov3, irdy3, cnt3, sq3, od3} !== exp3) begin
        bad++;
        $display("FAIL wrap_c%0d: got %h want %h", cyc, {ov3, irdy3, cnt3, sq3, od3}, exp3);
      end
    end
    iv3 = 1'b0;
    ordy3 = 1'b0;
    total++;
    if (got != 10) begin
      bad++;
      $display("FAIL wrap_done: got %0d beats want 10", got);
    end
  endtask

  task automatic test_reset_mid();
    logic        v_iv [6];
    logic [63:0] v_id [6];
    logic        v_fl [6];
    logic        v_or [6];
    logic        v_rs [6];
    logic [69:0] v_ex [6];
    v_iv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    v_id = '{64'h77, 64'h0, 64'hA1, 64'hA2, 64'hA3, 64'h0};
    v_fl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v_or = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    v_rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v_ex = '{{1'b1, 1'b1, 2'd1, 2'd0, 64'h77},
             {1'b0, 1'b1, 2'd0, 2'd1, 64'h0},
             {1'b1, 1'b1, 2'd1, 2'd1, 64'hA1},
             {1'b1, 1'b0, 2'd2, 2'd1, 64'hA1},
             {1'b0, 1'b1, 2'd0, 2'd0, 64'h0},
             {1'b0, 1'b1, 2'd0, 2'd0, 64'h0}};
    for (int i = 0; i < 6; i++) begin
      iv2   = v_iv[i];
      id2   = v_id[i];
      fl2   = v_fl[i];
      ordy2 = v_or[i];
      rst   = v_rs[i];
      step();
      total++;
      if ({ov2, irdy2, cnt2, sq2, od2} !== v_ex[i]) begin
        bad++;
        $display("FAIL rstmid_%0d: got %h want %h", i, {ov2, irdy2, cnt2, sq2, od2}, v_ex[i]);
      end
    end
    rst = 1'b0;
    iv2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
